// File: rtl/display_burst_buffer.sv
// display_burst_buffer
//
// Fill-then-drain buffer between a fast data producer and a slow,
// human-readable display. Words are collected over a valid/ready handshake
// until the buffer is full or flushed. Each stored word is then presented for
// a programmable number of cycles. Manual advance, abort and replay are
// supported.
//
// Parameters
//   width_p           data word width (>=1)
//   depth_p           number of stored words (>=2)
//   interval_width_p  width of the per-entry display interval
//
// Ports
//   clk_i        system clock
//   reset_i      asynchronous, active-high reset
//   valid_i      producer has a word on data_i
//   data_i       word to store
//   ready_o      block accepts a word this cycle (FILL)
//   flush_i      start draining a partial buffer / abort an active drain
//   advance_i    single-cycle pulse: show the next entry immediately
//   loop_i       replay from entry 0 after the last entry
//   interval_i   cycles each entry is shown (0 behaves as 1)
//   valid_o      data_o holds a displayed entry (DRAIN)
//   data_o       displayed word, 0 outside DRAIN
//   index_o      index of the displayed entry
//   count_o      number of stored words
//   draining_o   block is in DRAIN
//   done_o       one-cycle pulse when a non-looping drain pass completes

module display_burst_buffer #(
  parameter int width_p          = 8,
  parameter int depth_p          = 4,
  parameter int interval_width_p = 26
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         valid_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  input  logic                         flush_i,
  input  logic                         advance_i,
  input  logic                         loop_i,
  input  logic [interval_width_p-1:0]  interval_i,
  output logic                         valid_o,
  output logic [width_p-1:0]           data_o,
  output logic [$clog2(depth_p)-1:0]   index_o,
  output logic [$clog2(depth_p+1)-1:0] count_o,
  output logic                         draining_o,
  output logic                         done_o
);

  localparam int idx_w = $clog2(depth_p);
  localparam int cnt_w = $clog2(depth_p + 1);

  typedef enum logic {
    st_fill  = 1'b0,
    st_drain = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [cnt_w-1:0]              count_q, count_d;
  logic [idx_w-1:0]              index_q, index_d;
  logic [interval_width_p-1:0]   timer_q, timer_d;
  logic                          done_q, done_d;

  logic [width_p-1:0]            mem [depth_p];

  logic                          wr_en;
  logic [cnt_w-1:0]              count_inc;
  logic [interval_width_p-1:0]   timer_load;
  logic                          last_entry;
  logic                          step;

  assign wr_en      = (state_q == st_fill) && valid_i;
  assign count_inc  = count_q + cnt_w'(wr_en);
  // An interval of 0 would never expire on a down-counter; show it for 1 cycle.
  assign timer_load = (interval_i == '0) ? interval_width_p'(1) : interval_i;
  assign last_entry = !((cnt_w'(index_q) + cnt_w'(1)) < count_q);
  assign step       = (timer_q == interval_width_p'(1)) || advance_i;

  // NOTE: storage has no reset; stale contents are never visible because
  // count_q gates which entries can be displayed.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[count_q[idx_w-1:0]] <= data_i;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    case (state_q)
      st_fill: begin
        count_d = count_inc;
        // A same-cycle write is included in the flushed count.
        if ((flush_i && (count_inc != '0)) || (count_inc == cnt_w'(depth_p))) begin
          state_d = st_drain;
          index_d = '0;
          timer_d = timer_load;
        end
      end
      st_drain: begin
        if (flush_i) begin
          state_d = st_fill;
          count_d = '0;
          index_d = '0;
        end else if (step) begin
          if (!last_entry) begin
            index_d = index_q + idx_w'(1);
            timer_d = timer_load;
          end else if (loop_i) begin
            index_d = '0;
            timer_d = timer_load;
          end else begin
            state_d = st_fill;
            count_d = '0;
            index_d = '0;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q - interval_width_p'(1);
        end
      end
      default: state_d = st_fill;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= st_fill;
      count_q <= '0;
      index_q <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      timer_q <= timer_d;
      done_q  <= done_d;
    end
  end

  assign ready_o    = (state_q == st_fill);
  assign valid_o    = (state_q == st_drain);
  assign draining_o = (state_q == st_drain);
  assign data_o     = (state_q == st_drain) ? mem[index_q] : '0;
  assign index_o    = index_q;
  assign count_o    = count_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_display_burst_buffer.sv
// Directed testbench for display_burst_buffer (depth 4, width 8).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point,
// well away from the next edge.

module tb_display_burst_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic [7:0]  data_i;
  logic        ready_o;
  logic        flush_i;
  logic        advance_i;
  logic        loop_i;
  logic [25:0] interval_i;
  logic        valid_o;
  logic [7:0]  data_o;
  logic [1:0]  index_o;
  logic [2:0]  count_o;
  logic        draining_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  display_burst_buffer #(
    .width_p(8),
    .depth_p(4),
    .interval_width_p(26)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .valid_i(valid_i),
    .data_i(data_i),
    .ready_o(ready_o),
    .flush_i(flush_i),
    .advance_i(advance_i),
    .loop_i(loop_i),
    .interval_i(interval_i),
    .valid_o(valid_o),
    .data_o(data_o),
    .index_o(index_o),
    .count_o(count_o),
    .draining_o(draining_o),
    .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Writes four words back-to-back (first word in the top byte), then drops valid_i.
  task automatic fill_words(input logic [31:0] ws);
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1;
      data_i  = ws[31-8*i -: 8];
      tick();
    end
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b0; valid_i = 1'b0; data_i = '0; flush_i = 1'b0;
    advance_i = 1'b0; loop_i = 1'b0; interval_i = 26'd3;
    #1 reset_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1)    begin errors++; $display("FAIL reset ready_o: got %b want 1", ready_o); end
    checks++; if (valid_o !== 1'b0)    begin errors++; $display("FAIL reset valid_o: got %b want 0", valid_o); end
    checks++; if (draining_o !== 1'b0) begin errors++; $display("FAIL reset draining_o: got %b want 0", draining_o); end
    checks++; if (data_o !== 8'h00)    begin errors++; $display("FAIL reset data_o: got %h want 00", data_o); end
    checks++; if (index_o !== 2'd0)    begin errors++; $display("FAIL reset index_o: got %0d want 0", index_o); end
    checks++; if (count_o !== 3'd0)    begin errors++; $display("FAIL reset count_o: got %0d want 0", count_o); end
    checks++; if (done_o !== 1'b0)     begin errors++; $display("FAIL reset done_o: got %b want 0", done_o); end
    tick(); tick();
    #2 reset_i = 1'b0;
    tick();
    checks++; if (ready_o !== 1'b1 || count_o !== 3'd0) begin errors++; $display("FAIL post-reset idle: ready %b count %0d want 1/0", ready_o, count_o); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] w [4];
    w[0] = 8'h12; w[1] = 8'h34; w[2] = 8'h56; w[3] = 8'h78;
    interval_i = 26'd3; loop_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; data_i = w[i];
      tick();
      checks++; if (count_o !== 3'(i + 1)) begin errors++; $display("FAIL fill count_o: got %0d want %0d", count_o, i + 1); end
      if (i < 3) begin
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL fill ready_o after write %0d: got %b want 1", i, ready_o); end
      end
    end
    valid_i = 1'b0;
    checks++; if (ready_o !== 1'b0 || draining_o !== 1'b1) begin errors++; $display("FAIL fill->drain: ready %b draining %b want 0/1", ready_o, draining_o); end
    for (int e = 0; e < 4; e++) begin
      for (int c = 0; c < 3; c++) begin
        checks++; if (data_o !== w[e] || index_o !== 2'(e) || valid_o !== 1'b1 || done_o !== 1'b0) begin
          errors++; $display("FAIL drain entry %0d cycle %0d: data %h idx %0d valid %b done %b want %h/%0d/1/0", e, c, data_o, index_o, valid_o, done_o, w[e], e);
        end
        tick();
      end
    end
    checks++; if (done_o !== 1'b1 || ready_o !== 1'b1 || count_o !== 3'd0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL drain end: done %b ready %b count %0d valid %b want 1/1/0/0", done_o, ready_o, count_o, valid_o);
    end
    tick();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL done pulse width: got %b want 0", done_o); end
  endtask

  task automatic test_partial_flush();
    interval_i = 26'd3;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++; if (ready_o !== 1'b1 || draining_o !== 1'b0 || count_o !== 3'd0) begin
      errors++; $display("FAIL empty flush: ready %b draining %b count %0d want 1/0/0", ready_o, draining_o, count_o);
    end
    valid_i = 1'b1; data_i = 8'hA1; tick();
    data_i = 8'hB2; tick();
    valid_i = 1'b0; flush_i = 1'b1; tick();
    flush_i = 1'b0;
    checks++; if (count_o !== 3'd2 || draining_o !== 1'b1) begin errors++; $display("FAIL flush start: count %0d draining %b want 2/1", count_o, draining_o); end
    for (int e = 0; e < 2; e++) begin
      for (int c = 0; c < 3; c++) begin
        checks++; if (data_o !== ((e == 0) ? 8'hA1 : 8'hB2) || done_o !== 1'b0) begin
          errors++; $display("FAIL partial entry %0d cycle %0d: data %h done %b want %h/0", e, c, data_o, done_o, (e == 0) ? 8'hA1 : 8'hB2);
        end
        tick();
      end
    end
    checks++; if (done_o !== 1'b1 || ready_o !== 1'b1 || count_o !== 3'd0) begin
      errors++; $display("FAIL partial end: done %b ready %b count %0d want 1/1/0", done_o, ready_o, count_o);
    end
  endtask

  task automatic test_loop();
    logic [7:0] w [4];
    w[0] = 8'h12; w[1] = 8'h34; w[2] = 8'h56; w[3] = 8'h78;
    interval_i = 26'd2; loop_i = 1'b1;
    fill_words(32'h12345678);
    for (int p = 0; p < 2; p++) begin
      for (int e = 0; e < 4; e++) begin
        for (int c = 0; c < 2; c++) begin
          if (p == 1 && e == 0 && c == 0) loop_i = 1'b0;
          checks++; if (data_o !== w[e] || done_o !== 1'b0 || valid_o !== 1'b1) begin
            errors++; $display("FAIL loop pass %0d entry %0d cycle %0d: data %h done %b valid %b want %h/0/1", p, e, c, data_o, done_o, valid_o, w[e]);
          end
          tick();
        end
      end
    end
    checks++; if (done_o !== 1'b1 || ready_o !== 1'b1) begin errors++; $display("FAIL loop end: done %b ready %b want 1/1", done_o, ready_o); end
  endtask

  task automatic test_advance_abort();
    int held;
    interval_i = 26'd1000; loop_i = 1'b0;
    fill_words(32'h21436587);
    repeat (4) tick();
    checks++; if (index_o !== 2'd0 || data_o !== 8'h21) begin errors++; $display("FAIL advance pre: idx %0d data %h want 0/21", index_o, data_o); end
    advance_i = 1'b1;
    tick();
    advance_i = 1'b0;
    checks++; if (index_o !== 2'd1 || data_o !== 8'h43) begin errors++; $display("FAIL advance step: idx %0d data %h want 1/43", index_o, data_o); end
    held = 0;
    while (index_o == 2'd1 && held < 2000) begin
      held++;
      tick();
    end
    checks++; if (held != 1000) begin errors++; $display("FAIL advance hold: entry 1 shown %0d cycles want 1000", held); end
    checks++; if (index_o !== 2'd2 || data_o !== 8'h65) begin errors++; $display("FAIL after hold: idx %0d data %h want 2/65", index_o, data_o); end
    repeat (3) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++; if (ready_o !== 1'b1 || draining_o !== 1'b0 || count_o !== 3'd0 || index_o !== 2'd0 || data_o !== 8'h00 || done_o !== 1'b0) begin
      errors++; $display("FAIL abort: ready %b draining %b count %0d idx %0d data %h done %b want 1/0/0/0/00/0", ready_o, draining_o, count_o, index_o, data_o, done_o);
    end
    tick();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL abort done: got %b want 0", done_o); end
  endtask

  task automatic test_corners();
    logic [1:0] exp_idx [9];
    logic [7:0] w [4];
    w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h03; w[3] = 8'h04;
    exp_idx[0] = 2'd0; exp_idx[1] = 2'd0; exp_idx[2] = 2'd1; exp_idx[3] = 2'd2; exp_idx[4] = 2'd3;
    exp_idx[5] = 2'd0; exp_idx[6] = 2'd1; exp_idx[7] = 2'd2; exp_idx[8] = 2'd3;
    // Entry 0 starts with interval 2, then interval_i=0 gives 1-cycle entries;
    // 0xFF is offered on every drain cycle and must never appear.
    interval_i = 26'd2; loop_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; data_i = w[i]; tick();
    end
    data_i = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      if (k == 0) interval_i = 26'd0;
      if (k == 5) loop_i = 1'b0;
      checks++; if (index_o !== exp_idx[k] || data_o !== w[exp_idx[k]] || count_o !== 3'd4 || done_o !== 1'b0) begin
        errors++; $display("FAIL corner step %0d: idx %0d data %h count %0d done %b want %0d/%h/4/0", k, index_o, data_o, count_o, done_o, exp_idx[k], w[exp_idx[k]]);
      end
      tick();
    end
    valid_i = 1'b0;
    checks++; if (done_o !== 1'b1 || ready_o !== 1'b1 || count_o !== 3'd0) begin
      errors++; $display("FAIL corner end: done %b ready %b count %0d want 1/1/0", done_o, ready_o, count_o);
    end
    // Write and flush on the same edge at count 3 and at count 1.
    interval_i = 26'd1;
    valid_i = 1'b1;
    data_i = 8'h0A; tick();
    data_i = 8'h0B; tick();
    data_i = 8'h0C; tick();
    data_i = 8'h0D; flush_i = 1'b1; tick();
    valid_i = 1'b0; flush_i = 1'b0;
    checks++; if (count_o !== 3'd4 || draining_o !== 1'b1 || data_o !== 8'h0A) begin
      errors++; $display("FAIL write+flush@3: count %0d draining %b data %h want 4/1/0a", count_o, draining_o, data_o);
    end
    repeat (3) tick();
    checks++; if (data_o !== 8'h0D || index_o !== 2'd3) begin errors++; $display("FAIL write+flush@3 last: data %h idx %0d want 0d/3", data_o, index_o); end
    tick();
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL write+flush@3 done: got %b want 1", done_o); end
    valid_i = 1'b1; data_i = 8'h0E; tick();
    data_i = 8'h0F; flush_i = 1'b1; tick();
    valid_i = 1'b0; flush_i = 1'b0;
    checks++; if (count_o !== 3'd2 || data_o !== 8'h0E) begin errors++; $display("FAIL write+flush@1: count %0d data %h want 2/0e", count_o, data_o); end
    tick();
    checks++; if (data_o !== 8'h0F || index_o !== 2'd1) begin errors++; $display("FAIL write+flush@1 last: data %h idx %0d want 0f/1", data_o, index_o); end
    tick();
    checks++; if (done_o !== 1'b1 || ready_o !== 1'b1) begin errors++; $display("FAIL write+flush@1 done: done %b ready %b want 1/1", done_o, ready_o); end
  endtask

  task automatic test_async_reset();
    interval_i = 26'd5; loop_i = 1'b0;
    fill_words(32'hC1C2C3C4);
    repeat (5) tick();
    checks++; if (index_o !== 2'd1 || data_o !== 8'hC2) begin errors++; $display("FAIL pre-reset drain: idx %0d data %h want 1/c2", index_o, data_o); end
    #2 reset_i = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0 || data_o !== 8'h00 || index_o !== 2'd0 || count_o !== 3'd0 || ready_o !== 1'b1 || draining_o !== 1'b0) begin
      errors++; $display("FAIL async reset: valid %b data %h idx %0d count %0d ready %b draining %b want 0/00/0/0/1/0", valid_o, data_o, index_o, count_o, ready_o, draining_o);
    end
    valid_i = 1'b1; data_i = 8'h55; flush_i = 1'b1;
    tick(); tick();
    checks++; if (count_o !== 3'd0 || ready_o !== 1'b1 || draining_o !== 1'b0) begin
      errors++; $display("FAIL held in reset: count %0d ready %b draining %b want 0/1/0", count_o, ready_o, draining_o);
    end
    #2 reset_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    tick();
    checks++; if (count_o !== 3'd0 || ready_o !== 1'b1 || draining_o !== 1'b0) begin
      errors++; $display("FAIL after reset release: count %0d ready %b draining %b want 0/1/0", count_o, ready_o, draining_o);
    end
    valid_i = 1'b1; data_i = 8'h99; tick();
    valid_i = 1'b0; flush_i = 1'b1; tick();
    flush_i = 1'b0;
    checks++; if (data_o !== 8'h99 || count_o !== 3'd1) begin errors++; $display("FAIL resume: data %h count %0d want 99/1", data_o, count_o); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_partial_flush();
    test_loop();
    test_advance_abort();
    test_corners();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
